axi_rd_arbiter: RTL and testbench

- Shares the single AXI read master port between the instruction fetch path (ARID 0) and the data-memory read path (ARID 1).
- Registers the AR channel and arbitrates requests with data priority plus an anti-starvation counter.
- Tracks at most one outstanding read per ID and routes R beats back to the owner by RID.
- Exports data-read progress so the fetch stage can tell its own returns apart from data returns on the shared R channel.

---
 rtl/axi_rd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master between instruction fetch and data reads.
// Data has priority; a starve counter forces a waiting fetch through.
module axi_rd_arbiter #(
  parameter int unsigned STARVE_MAX = 2,
  parameter logic [3:0]  INST_ID    = 4'd0,
  parameter logic [3:0]  DATA_ID    = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req_valid,
  input  logic [31:0] inst_req_addr,
  output logic        inst_req_ready,
  input  logic        data_req_valid,
  input  logic [31:0] data_req_addr,
  input  logic [2:0]  data_req_size,
  output logic        data_req_ready,
  output logic [1:0]  data_r_req,
  output logic        inst_resp_valid,
  output logic [31:0] inst_resp_data,
  input  logic        inst_resp_ready,
  output logic        data_resp_valid,
  output logic [31:0] data_resp_data,
  input  logic        data_resp_ready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  // Handshakes: a transfer happens on any clock edge where valid && ready;
  // a source holds its payload stable while valid && !ready.

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_AR   = 2'd1,
    DR_R    = 2'd2
  } dr_state_e;

  dr_state_e   dr_q;
  logic        arvalid_q, arvalid_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        inst_out_q, inst_out_d;
  logic        data_out_q, data_out_d;
  logic [1:0]  starve_q, starve_d;

  logic slot_free, inst_elig, data_elig, grant_inst, grant_data;
  logic ar_hs, inst_hit, data_hit, rready_w, r_hs, inst_done, data_done;

  assign slot_free  = !arvalid_q || arready;
  assign inst_elig  = inst_req_valid && !inst_out_q;
  assign data_elig  = data_req_valid && !data_out_q;
  assign grant_inst = resetn && slot_free && inst_elig &&
                      (!data_elig || (starve_q == STARVE_LIM));
  assign grant_data = resetn && slot_free && data_elig && !grant_inst;

  assign ar_hs = arvalid_q && arready;

  // Beats for an ID with no outstanding read are accepted and dropped.
  assign inst_hit = (rid == INST_ID) && inst_out_q;
  assign data_hit = (rid == DATA_ID) && data_out_q && !inst_hit;

  always_comb begin
    rready_w = 1'b1;
    if (!resetn)       rready_w = 1'b0;
    else if (inst_hit) rready_w = inst_resp_ready;
    else if (data_hit) rready_w = data_resp_ready;
  end

  assign r_hs      = rvalid && rready_w;
  assign inst_done = r_hs && rlast && inst_hit;
  assign data_done = r_hs && rlast && data_hit;

  always_comb begin
    arvalid_d  = arvalid_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    inst_out_d = inst_out_q;
    data_out_d = data_out_q;
    starve_d   = starve_q;

    if (grant_inst) begin
      arvalid_d = 1'b1;
      arid_d    = INST_ID;
      araddr_d  = inst_req_addr;
      arsize_d  = 3'd2;
    end else if (grant_data) begin
      arvalid_d = 1'b1;
      arid_d    = DATA_ID;
      araddr_d  = data_req_addr;
      arsize_d  = data_req_size;
    end else if (arready) begin
      arvalid_d = 1'b0;
    end

    if (inst_done)  inst_out_d = 1'b0;
    if (grant_inst) inst_out_d = 1'b1;
    if (data_done)  data_out_d = 1'b0;
    if (grant_data) data_out_d = 1'b1;

    if (grant_inst || !inst_elig)              starve_d = 2'd0;
    else if (grant_data && starve_q != STARVE_LIM) starve_d = starve_q + 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q  <= 1'b0;
      arid_q     <= 4'd0;
      araddr_q   <= 32'd0;
      arsize_q   <= 3'd0;
      inst_out_q <= 1'b0;
      data_out_q <= 1'b0;
      starve_q   <= 2'd0;
    end else begin
      arvalid_q  <= arvalid_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      inst_out_q <= inst_out_d;
      data_out_q <= data_out_d;
      starve_q   <= starve_d;
    end
  end

  // Data-read progress as seen by the fetch stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dr_q <= DR_IDLE;
    end else begin
      case (dr_q)
        DR_IDLE: if (grant_data) dr_q <= DR_AR;
        DR_AR:   if (ar_hs && arid_q == DATA_ID) dr_q <= DR_R;
        DR_R:    if (data_done) dr_q <= DR_IDLE;
        default: dr_q <= DR_IDLE;
      endcase
    end
  end

  assign data_r_req      = dr_q;
  assign inst_req_ready  = grant_inst;
  assign data_req_ready  = grant_data;
  assign arvalid         = arvalid_q;
  assign arid            = arid_q;
  assign araddr          = araddr_q;
  assign arsize          = arsize_q;
  assign arlen           = 8'd0;
  assign arburst         = 2'b01;
  assign rready          = rready_w;
  assign inst_resp_valid = resetn && rvalid && inst_hit;
  assign data_resp_valid = resetn && rvalid && data_hit;
  assign inst_resp_data  = {32{resetn}} & rdata;
  assign data_resp_data  = {32{resetn}} & rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: AR and R responses are checked by a
// negedge monitor against expected queues filled by the stimulus thread.
module tb_axi_rd_arbiter;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  logic        clk, resetn;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        data_req_valid, data_req_ready;
  logic [31:0] data_req_addr;
  logic [2:0]  data_req_size;
  logic [1:0]  data_r_req;
  logic        inst_resp_valid, inst_resp_ready;
  logic [31:0] inst_resp_data;
  logic        data_resp_valid, data_resp_ready;
  logic [31:0] data_resp_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  logic [38:0] exp_ar_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  logic [38:0] ar_exp;
  logic [31:0] r_exp;

  axi_rd_arbiter #(.STARVE_MAX(2), .INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
    .inst_req_ready(inst_req_ready),
    .data_req_valid(data_req_valid), .data_req_addr(data_req_addr),
    .data_req_size(data_req_size), .data_req_ready(data_req_ready),
    .data_r_req(data_r_req),
    .inst_resp_valid(inst_resp_valid), .inst_resp_data(inst_resp_data),
    .inst_resp_ready(inst_resp_ready),
    .data_resp_valid(data_resp_valid), .data_resp_data(data_resp_data),
    .data_resp_ready(data_resp_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size);
    exp_ar_q.push_back({id, size, addr});
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
    int n;
    n = 0;
    rid = id; rdata = d; rlast = 1'b1; rvalid = 1'b1;
    @(negedge clk);
    while (!rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("r_beat_accept", rready, 1);
    tick();
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) chk("ar_unexpected", {arid, arsize, araddr}, 0);
        else begin
          ar_exp = exp_ar_q.pop_front();
          chk("ar_beat", {arid, arsize, araddr}, ar_exp);
        end
      end
      if (inst_resp_valid && inst_resp_ready) begin
        if (exp_inst_q.size() == 0) chk("inst_resp_unexpected", inst_resp_data, 0);
        else begin
          r_exp = exp_inst_q.pop_front();
          chk("inst_resp_data", inst_resp_data, r_exp);
        end
      end
      if (data_resp_valid && data_resp_ready) begin
        if (exp_data_q.size() == 0) chk("data_resp_unexpected", data_resp_data, 0);
        else begin
          r_exp = exp_data_q.pop_front();
          chk("data_resp_data", data_resp_data, r_exp);
        end
      end
    end
  end

  initial begin
    int arb, inst_arb;
    logic first_data;
    resetn = 1'b0;
    inst_req_valid = 1'b1; inst_req_addr = 32'h0;
    data_req_valid = 1'b1; data_req_addr = 32'h0; data_req_size = 3'd0;
    inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rlast = 1'b0; rvalid = 1'b1;

    // reset state, requests and beats present must be ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arburst", arburst, 2'b01);
    chk("rst_rready", rready, 0);
    chk("rst_data_r_req", data_r_req, 0);
    chk("rst_inst_ready", inst_req_ready, 0);
    chk("rst_data_ready", data_req_ready, 0);
    inst_req_valid = 1'b0; data_req_valid = 1'b0; rvalid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // single fetch
    arready = 1'b1;
    inst_req_valid = 1'b1; inst_req_addr = 32'hbfc00000;
    push_ar(INST_ID, 32'hbfc00000, 3'd2);
    @(negedge clk);
    chk("t1_inst_ready", inst_req_ready, 1);
    tick();
    inst_req_valid = 1'b0;
    @(negedge clk);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_arid", arid, INST_ID);
    chk("t1_arsize", arsize, 3'd2);
    tick();
    rid = INST_ID; rdata = 32'h24080001; rlast = 1'b1; rvalid = 1'b1;
    inst_resp_ready = 1'b1;
    exp_inst_q.push_back(32'h24080001);
    inst_req_valid = 1'b1; inst_req_addr = 32'hbfc00004;
    @(negedge clk);
    chk("t1_resp_valid", inst_resp_valid, 1);
    chk("t1_rready", rready, 1);
    chk("t1_bubble_ready", inst_req_ready, 0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    chk("t1_regrant_ready", inst_req_ready, 1);
    push_ar(INST_ID, 32'hbfc00004, 3'd2);
    tick();
    inst_req_valid = 1'b0;
    tick();
    exp_inst_q.push_back(32'h3c1d8000);
    r_beat(INST_ID, 32'h3c1d8000);

    // collision: data first, then inst
    inst_req_valid = 1'b1; inst_req_addr = 32'hbfc00008;
    data_req_valid = 1'b1; data_req_addr = 32'h00001000; data_req_size = 3'd0;
    push_ar(DATA_ID, 32'h00001000, 3'd0);
    push_ar(INST_ID, 32'hbfc00008, 3'd2);
    @(negedge clk);
    chk("t2_data_ready", data_req_ready, 1);
    chk("t2_inst_ready", inst_req_ready, 0);
    chk("t2_drq0", data_r_req, 0);
    tick();
    data_req_valid = 1'b0;
    @(negedge clk);
    chk("t2_drq1", data_r_req, 1);
    chk("t2_arid", arid, DATA_ID);
    chk("t2_arsize", arsize, 3'd0);
    chk("t2_inst_next", inst_req_ready, 1);
    tick();
    inst_req_valid = 1'b0;
    @(negedge clk);
    chk("t2_drq2", data_r_req, 2);
    chk("t2_arid_inst", arid, INST_ID);
    tick();
    data_resp_ready = 1'b1;
    exp_data_q.push_back(32'hdeadbeef);
    r_beat(DATA_ID, 32'hdeadbeef);
    @(negedge clk);
    chk("t2_drq_back0", data_r_req, 0);
    tick();
    exp_inst_q.push_back(32'h27bdffe8);
    r_beat(INST_ID, 32'h27bdffe8);

    // starvation: inst held, data re-requests with immediate returns
    inst_req_valid = 1'b1; inst_req_addr = 32'hbfc00010;
    data_req_valid = 1'b1; data_req_addr = 32'h00004000; data_req_size = 3'd2;
    arb = 0; inst_arb = 0; first_data = 1'b0;
    for (int c = 0; c < 12 && inst_arb == 0; c++) begin
      @(negedge clk);
      if (data_req_ready) begin
        arb++;
        if (arb == 1) first_data = 1'b1;
        push_ar(DATA_ID, data_req_addr, data_req_size);
      end
      if (inst_req_ready) begin
        arb++;
        inst_arb = arb;
        push_ar(INST_ID, inst_req_addr, 3'd2);
      end
      tick();
      if (data_req_ready === 1'b0 && arb > 0) data_req_addr = data_req_addr + 32'd4;
      if (data_r_req == 2'd2 && !rvalid) begin
        rid = DATA_ID; rdata = 32'hd0000000 | 32'(c); rlast = 1'b1; rvalid = 1'b1;
        exp_data_q.push_back(rdata);
      end else begin
        rvalid = 1'b0;
      end
    end
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    chk("t3_first_is_data", first_data, 1);
    chk("t3_inst_by_arb3", (inst_arb >= 1 && inst_arb <= 3), 1);
    if (rvalid) begin
      @(negedge clk);
      chk("t3_data_r_accept", rready, 1);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
    end
    tick();
    exp_inst_q.push_back(32'h00000013);
    r_beat(INST_ID, 32'h00000013);

    // AR backpressure
    arready = 1'b0;
    data_req_valid = 1'b1; data_req_addr = 32'h00002000; data_req_size = 3'd1;
    push_ar(DATA_ID, 32'h00002000, 3'd1);
    @(negedge clk);
    chk("t4_data_ready", data_req_ready, 1);
    tick();
    data_req_valid = 1'b0;
    inst_req_valid = 1'b1; inst_req_addr = 32'hbfc0000c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_arvalid", arvalid, 1);
      chk("t4_araddr", araddr, 32'h00002000);
      chk("t4_arid", arid, DATA_ID);
      chk("t4_inst_ready", inst_req_ready, 0);
      chk("t4_data_ready0", data_req_ready, 0);
      chk("t4_drq1", data_r_req, 1);
      tick();
    end
    arready = 1'b1;
    @(negedge clk);
    chk("t4_inst_on_release", inst_req_ready, 1);
    push_ar(INST_ID, 32'hbfc0000c, 3'd2);
    tick();
    inst_req_valid = 1'b0;
    @(negedge clk);
    chk("t4_drq2", data_r_req, 2);
    tick();

    // out-of-order R: data returns first under consumer backpressure
    rid = DATA_ID; rdata = 32'h0badf00d; rlast = 1'b1; rvalid = 1'b1;
    data_resp_ready = 1'b0; inst_resp_ready = 1'b1;
    exp_data_q.push_back(32'h0badf00d);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_rready_hold", rready, 0);
      chk("t5_data_valid", data_resp_valid, 1);
      chk("t5_inst_valid", inst_resp_valid, 0);
      chk("t5_drq2", data_r_req, 2);
      tick();
    end
    data_resp_ready = 1'b1;
    @(negedge clk);
    chk("t5_rready", rready, 1);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    chk("t5_drq0", data_r_req, 0);
    tick();
    exp_inst_q.push_back(32'h8c080000);
    r_beat(INST_ID, 32'h8c080000);

    // reset mid-op, then a stale data beat is drained
    data_req_valid = 1'b1; data_req_addr = 32'h00003000; data_req_size = 3'd2;
    push_ar(DATA_ID, 32'h00003000, 3'd2);
    @(negedge clk);
    tick();
    data_req_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t6_drq2", data_r_req, 2);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_arvalid", arvalid, 0);
    chk("t6_rst_drq", data_r_req, 0);
    chk("t6_rst_rready", rready, 0);
    tick();
    resetn = 1'b1;
    rid = DATA_ID; rdata = 32'hcafef00d; rlast = 1'b1; rvalid = 1'b1;
    data_resp_ready = 1'b0;
    @(negedge clk);
    chk("t6_stale_rready", rready, 1);
    chk("t6_stale_valid", data_resp_valid, 0);
    chk("t6_stale_drq", data_r_req, 0);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    tick();

    chk("end_ar_q_empty", exp_ar_q.size(), 0);
    chk("end_inst_q_empty", exp_inst_q.size(), 0);
    chk("end_data_q_empty", exp_data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
